fft_frame_driver: RTL

Host-side sequencer for the 64-point fft_controller.
- Collects a frame of 64 real audio samples from the ADC stream into an internal buffer.
- Plays the frame into the FFT over the load/address/data interface, then pulses start.
- Captures the 64 complex output words while the FFT asserts done, converts each to an approximate magnitude, and stores it in a bin buffer.
- The display/classifier logic reads the bin buffer. This block is the initiator counterpart of fft_controller's load/start/done protocol.

---
 rtl/fft_frame_driver.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_driver.sv
// rtl/fft_frame_driver.sv - frame collect, FFT load/start/drain and magnitude bin buffer
//
// Collects N real samples, plays them into the FFT core over the
// load/address/data interface, pulses start, then captures N complex result
// words while the core asserts done and stores |re|+|im| per bin.
//
// Ports:
//   slow_clk     clock for all logic, including the FFT handshake
//   reset        synchronous, active-low
//   sample_valid one-cycle strobe qualifying sample
//   sample       signed audio sample
//   fft_load     high for the N load cycles
//   fft_adr      load address (sample index while loading)
//   fft_rd       load word {sample, zero imaginary}
//   fft_start    one-cycle start pulse after the load phase
//   fft_done     FFT result valid, one word per cycle while high
//   fft_wd       FFT result {re, im}, signed
//   res_adr      bin buffer read address
//   res_mag      registered magnitude of bin res_adr (1-cycle latency)
//   frame_ready  one-cycle pulse after the last bin is written
//   busy         high in every state except COLLECT
//   overrun      sticky: a sample arrived outside COLLECT
//   fft_err      sticky: FFT never answered within TIMEOUT cycles
module fft_frame_driver #(
   parameter int N        = 64,
   parameter int SAMPLE_W = 16,
   parameter int TIMEOUT  = 4096
) (
   input  logic                    slow_clk,
   input  logic                    reset,
   input  logic                    sample_valid,
   input  logic [SAMPLE_W-1:0]     sample,
   output logic                    fft_load,
   output logic [$clog2(N)-1:0]    fft_adr,
   output logic [2*SAMPLE_W-1:0]   fft_rd,
   output logic                    fft_start,
   input  logic                    fft_done,
   input  logic [2*SAMPLE_W-1:0]   fft_wd,
   input  logic [$clog2(N)-1:0]    res_adr,
   output logic [SAMPLE_W:0]       res_mag,
   output logic                    frame_ready,
   output logic                    busy,
   output logic                    overrun,
   output logic                    fft_err
);

   localparam int AW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [2:0] {
      S_COLLECT,
      S_LOAD,
      S_START,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t              state;
   logic [AW-1:0]       cnt;
   logic [TW-1:0]       timer;

   logic [SAMPLE_W-1:0] sbuf [N];
   logic [SAMPLE_W:0]   bbuf [N];

   logic                sbuf_we;
   logic                bbuf_we;
   logic [AW-1:0]       bbuf_wa;
   logic [AW-1:0]       adr_nxt;
   logic signed [SAMPLE_W:0] re_x;
   logic signed [SAMPLE_W:0] im_x;
   logic [SAMPLE_W:0]   abs_re;
   logic [SAMPLE_W:0]   abs_im;
   logic [SAMPLE_W:0]   mag;

   // Buffer write enables are gated by reset so an aborted cycle writes nothing.
   // The first result word arrives in WAIT and always lands in bin 0.
   always_comb begin
      sbuf_we = reset && (state == S_COLLECT) && sample_valid;
      bbuf_we = reset && fft_done && ((state == S_WAIT) || (state == S_DRAIN));
      bbuf_wa = (state == S_WAIT) ? '0 : cnt;
      adr_nxt = fft_adr + AW'(1);
   end

   // Magnitude approximation |re|+|im|. Sign-extending by one bit keeps
   // |-32768| representable; the sum of two such values still fits.
   always_comb begin
      re_x   = {fft_wd[2*SAMPLE_W-1], fft_wd[2*SAMPLE_W-1:SAMPLE_W]};
      im_x   = {fft_wd[SAMPLE_W-1], fft_wd[SAMPLE_W-1:0]};
      abs_re = re_x[SAMPLE_W] ? -re_x : re_x;
      abs_im = im_x[SAMPLE_W] ? -im_x : im_x;
      mag    = abs_re + abs_im;
   end

   // Sample and bin storage; contents survive reset.
   always_ff @(posedge slow_clk) begin
      if (sbuf_we) begin
         sbuf[cnt] <= sample;
      end
      if (bbuf_we) begin
         bbuf[bbuf_wa] <= mag;
      end
   end

   // Registered read port; a same-cycle write to res_adr returns the old value.
   always_ff @(posedge slow_clk) begin
      if (!reset) begin
         res_mag <= '0;
      end else begin
         res_mag <= bbuf[res_adr];
      end
   end

   always_ff @(posedge slow_clk) begin
      if (!reset) begin
         state       <= S_COLLECT;
         cnt         <= '0;
         timer       <= '0;
         fft_load    <= 1'b0;
         fft_adr     <= '0;
         fft_rd      <= '0;
         fft_start   <= 1'b0;
         frame_ready <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         fft_err     <= 1'b0;
      end else begin
         frame_ready <= 1'b0;
         fft_start   <= 1'b0;

         if (sample_valid && (state != S_COLLECT)) begin
            overrun <= 1'b1;
         end

         case (state)
            S_COLLECT: begin
               if (sample_valid) begin
                  if (cnt == LAST) begin
                     // Present load word 0 right away so load starts the
                     // cycle after the last sample strobe.
                     cnt      <= '0;
                     state    <= S_LOAD;
                     fft_load <= 1'b1;
                     fft_adr  <= '0;
                     fft_rd   <= {sbuf[0], {SAMPLE_W{1'b0}}};
                     busy     <= 1'b1;
                  end else begin
                     cnt <= cnt + AW'(1);
                  end
               end
            end

            // fft_adr is the index currently presented on the load bus.
            S_LOAD: begin
               if (fft_adr == LAST) begin
                  state     <= S_START;
                  fft_load  <= 1'b0;
                  fft_adr   <= '0;
                  fft_rd    <= '0;
                  fft_start <= 1'b1;
               end else begin
                  fft_adr <= adr_nxt;
                  fft_rd  <= {sbuf[adr_nxt], {SAMPLE_W{1'b0}}};
               end
            end

            S_START: begin
               state <= S_WAIT;
               timer <= '0;
            end

            S_WAIT: begin
               if (fft_done) begin
                  state <= S_DRAIN;
                  cnt   <= AW'(1);
                  timer <= '0;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  fft_err <= 1'b1;
                  state   <= S_COLLECT;
                  cnt     <= '0;
                  timer   <= '0;
                  busy    <= 1'b0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            // Done may gap; cnt only advances on captured words.
            S_DRAIN: begin
               if (fft_done) begin
                  if (cnt == LAST) begin
                     frame_ready <= 1'b1;
                     cnt         <= '0;
                     state       <= S_COLLECT;
                     busy        <= 1'b0;
                  end else begin
                     cnt <= cnt + AW'(1);
                  end
               end
            end

            default: begin
               state    <= S_COLLECT;
               cnt      <= '0;
               fft_load <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
